// File: rtl/sniff_fifo.sv
// First-word-fall-through sniffer FIFO with registered occupancy flags and
// sticky overflow/underflow reporting.
module sniff_fifo #(
  parameter int pDEPTH     = 512,
  parameter int pAF_MARGIN = 8,
  parameter int pAE_MARGIN = 4
) (
  input  logic                      cwusb_clk,
  input  logic                      reset_i,
  input  logic                      I_flush,
  input  logic                      I_clear_flags,
  input  logic                      I_wr_en,
  input  logic [17:0]               I_wr_data,
  input  logic                      I_fifo_read,
  output logic [17:0]               O_fifo_data,
  output logic                      O_fifo_empty,
  output logic [5:0]                O_fifo_status,
  output logic [$clog2(pDEPTH):0]   O_count
);

  localparam int AW = $clog2(pDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(pDEPTH);
  localparam logic [CW-1:0] AF_C      = CW'(pAF_MARGIN);
  localparam logic [CW-1:0] AE_C      = CW'(pAE_MARGIN);
  localparam logic          AF_AT_0   = (pDEPTH <= pAF_MARGIN);

  logic [17:0]   mem [pDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n, free_n;
  logic          full, almost_full, almost_empty, empty;
  logic          overflow, underflow;
  logic          wr_ok, rd_ok, ovf_n, udf_n;

  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no latch can be inferred.
  always_comb begin
    rd_ok   = I_fifo_read && (count != '0);
    wr_ok   = I_wr_en && ((count != DEPTH_C) || rd_ok);
    count_n = count;
    if (wr_ok && !rd_ok)
      count_n = count + 1'b1;
    else if (rd_ok && !wr_ok)
      count_n = count - 1'b1;
    free_n  = DEPTH_C - count_n;
    // A fresh event beats a coincident clear.
    ovf_n   = (overflow  && !I_clear_flags) || (I_wr_en && !wr_ok);
    udf_n   = (underflow && !I_clear_flags) || (I_fifo_read && !rd_ok);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= AF_AT_0;
      almost_empty <= 1'b1;
      empty        <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (I_flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= AF_AT_0;
      almost_empty <= 1'b1;
      empty        <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count        <= count_n;
      full         <= (count_n == DEPTH_C);
      almost_full  <= (free_n <= AF_C);
      almost_empty <= (count_n <= AE_C);
      empty        <= (count_n == '0);
      overflow     <= ovf_n;
      underflow    <= udf_n;
    end
  end

  // NOTE: the storage array has no reset; pointers and count define validity,
  // so stale contents are never observable.
  always_ff @(posedge cwusb_clk) begin
    if (wr_ok && !I_flush)
      mem[wr_ptr] <= I_wr_data;
  end

  // Head entry read straight from the array gives fall-through with one
  // cycle of write-to-output latency and no path from the strobes.
  assign O_fifo_data   = mem[rd_ptr];
  assign O_fifo_empty  = empty;
  assign O_count       = count;
  assign O_fifo_status = {underflow, overflow, full, almost_full, almost_empty, empty};

endmodule
